// File: rtl/arb_requester.sv
// arb_requester: client-side agent for the two-way req/gnt arbiter.
// Jobs from local logic queue in a small FIFO. Each job is turned into a
// request, a granted burst of job_len+1 beats, and a one-cycle release.
// Optional feature macro: REQ_TIMEOUT_EN. When it is defined, a request that
// waits TIMEOUT cycles without a grant is abandoned and timeout_err pulses.
module arb_requester #(
   parameter int DATA_W  = 8,
   parameter int LEN_W   = 4,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              job_valid,
   output logic              job_ready,
   input  logic [LEN_W-1:0]  job_len,
   input  logic [DATA_W-1:0] job_data,
   output logic              req,
   input  logic              gnt,
   output logic              bus_valid,
   output logic [DATA_W-1:0] bus_data,
   output logic              bus_last,
   output logic              busy,
   output logic              timeout_err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      XFER = 2'd2,
      REL  = 2'd3
   } state_t;

   // Refuse to elaborate with a FIFO depth the pointer arithmetic cannot handle
   // or a timeout limit that could never be reached.
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_cfg
      $error("arb_requester: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
   end

   state_t             state;
   state_t             nextState;

   logic [LEN_W-1:0]   lenMem  [DEPTH];
   logic [DATA_W-1:0]  dataMem [DEPTH];
   logic [PTR_W-1:0]   wrPtr;
   logic [PTR_W-1:0]   rdPtr;
   logic [CNT_W-1:0]   count;
   logic               full;
   logic               empty;
   logic               push;
   logic               pop;

   logic [LEN_W-1:0]   curLen;
   logic [DATA_W-1:0]  curData;
   logic [LEN_W-1:0]   beat;
   logic               reqQ;
   logic               abort;

   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign job_ready = !full;

   // A full FIFO refuses new jobs even when a pop happens on the same edge.
   assign push = job_valid && !full;
   assign pop  = (state == IDLE) && !empty;

   assign bus_valid = (state == XFER) && gnt;
   assign bus_data  = curData + DATA_W'(beat);
   assign bus_last  = bus_valid && (beat == curLen);
   assign busy      = (state != IDLE) || !empty;
   assign req       = reqQ;

   // Job storage is plain memory; occupancy is tracked by the pointers, so no reset is needed here.
   always_ff @(posedge clk) begin
      if (push) begin
         lenMem[wrPtr]  <= job_len;
         dataMem[wrPtr] <= job_data;
      end
   end

   // FIFO pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (pop) begin
            rdPtr <= rdPtr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

`ifdef REQ_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);

   logic [TO_W-1:0] waitCount;
   logic            timeoutQ;

   // Count ungranted cycles spent in REQ; the count restarts with every newly popped job.
   always_ff @(posedge clk) begin
      if (rst || pop) begin
         waitCount <= '0;
      end else if ((state == REQ) && !gnt) begin
         waitCount <= waitCount + 1'b1;
      end
   end

   // The abort decision is registered so the error pulse lines up with the release cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         timeoutQ <= 1'b0;
      end else begin
         timeoutQ <= abort;
      end
   end

   assign timeout_err = timeoutQ;
`else
   assign timeout_err = 1'b0;
`endif

   // Next-state decode: wait for grant, stream until the last beat, then release for one cycle.
   always_comb begin
      nextState = state;
      abort     = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               nextState = REQ;
            end
         end
         REQ: begin
            if (gnt) begin
               nextState = XFER;
            end
`ifdef REQ_TIMEOUT_EN
            else if (waitCount == TO_W'(TIMEOUT - 1)) begin
               nextState = REL;
               abort     = 1'b1;
            end
`endif
         end
         XFER: begin
            if (bus_last) begin
               nextState = REL;
            end
         end
         REL: begin
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // State register plus a registered req that follows the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         reqQ  <= 1'b0;
      end else begin
         state <= nextState;
         reqQ  <= (nextState == REQ) || (nextState == XFER);
      end
   end

   // Current job registers and beat counter; a grant stall simply holds the beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         curLen  <= '0;
         curData <= '0;
         beat    <= '0;
      end else if (pop) begin
         curLen  <= lenMem[rdPtr];
         curData <= dataMem[rdPtr];
         beat    <= '0;
      end else if (bus_valid) begin
         beat    <= beat + 1'b1;
      end
   end

endmodule

// File: tb/tb_arb_requester.sv
// Self-checking bench for arb_requester. A job-level reference model tracks
// the queued jobs and the job in hand and predicts every output each cycle.
// Honours REQ_TIMEOUT_EN when the bench is built with the same macro.
module tb_arb_requester;

   localparam int DATA_W  = 8;
   localparam int LEN_W   = 4;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              job_valid;
   logic              job_ready;
   logic [LEN_W-1:0]  job_len;
   logic [DATA_W-1:0] job_data;
   logic              req;
   logic              gnt;
   logic              bus_valid;
   logic [DATA_W-1:0] bus_data;
   logic              bus_last;
   logic              busy;
   logic              timeout_err;

   int totalCnt = 0;
   int passCnt  = 0;

   // Reference model: queue of waiting jobs plus the job currently owned.
   int qLen  [$];
   int qData [$];
   bit mHold    = 0;
   bit mGranted = 0;
   bit mCool    = 0;
   bit mTerr    = 0;
   int mLen     = 0;
   int mData    = 0;
   int mSent    = 0;
   int mWait    = 0;

   arb_requester #(
      .DATA_W (DATA_W),
      .LEN_W  (LEN_W),
      .DEPTH  (DEPTH),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .job_valid  (job_valid),
      .job_ready  (job_ready),
      .job_len    (job_len),
      .job_data   (job_data),
      .req        (req),
      .gnt        (gnt),
      .bus_valid  (bus_valid),
      .bus_data   (bus_data),
      .bus_last   (bus_last),
      .busy       (busy),
      .timeout_err(timeout_err)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      totalCnt++;
      assert (obs === exp) passCnt++;
      else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Compare every DUT output against what the model predicts for this cycle.
   task automatic checkAll();
      bit expValid;
      expValid = mHold && mGranted && gnt;
      checkOutput("req", req, mHold);
      checkOutput("bus_valid", bus_valid, expValid);
      checkOutput("bus_last", bus_last, expValid && (mSent == mLen));
      if (expValid) begin
         checkOutput("bus_data", bus_data, (mData + mSent) % 256);
      end
      checkOutput("job_ready", job_ready, qLen.size() < DEPTH);
      checkOutput("busy", busy, mHold || mCool || (qLen.size() > 0));
      checkOutput("timeout_err", timeout_err, mTerr);
   endtask

   // Advance the model by one clock edge using the inputs held across that edge.
   task automatic modelEdge();
      int sz;
      bit accept;
      bit terrNext;
      if (rst) begin
         qLen.delete();
         qData.delete();
         mHold    = 0;
         mGranted = 0;
         mCool    = 0;
         mTerr    = 0;
         mSent    = 0;
         mWait    = 0;
         mLen     = 0;
         mData    = 0;
      end else begin
         sz       = qLen.size();
         accept   = job_valid && (sz < DEPTH);
         terrNext = 0;
         if (mCool) begin
            mCool = 0;
         end else if (!mHold) begin
            if (sz > 0) begin
               mLen     = qLen.pop_front();
               mData    = qData.pop_front();
               mHold    = 1;
               mGranted = 0;
               mSent    = 0;
               mWait    = 0;
            end
         end else if (!mGranted) begin
            if (gnt) mGranted = 1;
`ifdef REQ_TIMEOUT_EN
            else begin
               mWait++;
               if (mWait == TIMEOUT) begin
                  mHold    = 0;
                  mCool    = 1;
                  terrNext = 1;
               end
            end
`endif
         end else if (gnt) begin
            mSent++;
            if (mSent == mLen + 1) begin
               mHold = 0;
               mCool = 1;
            end
         end
         if (accept) begin
            qLen.push_back(int'(job_len));
            qData.push_back(int'(job_data));
         end
         mTerr = terrNext;
      end
   endtask

   // Drive one cycle of inputs, check mid-cycle, then step the model at the edge.
   task automatic applyStimulus(input bit r, input bit v, input int len, input int data, input bit g);
      rst       = r;
      job_valid = v;
      job_len   = LEN_W'(len);
      job_data  = DATA_W'(data);
      gnt       = g;
      @(negedge clk);
      checkAll();
      @(posedge clk);
      modelEdge();
      #1;
   endtask

   // Directed scenarios first, then a randomized soak, then the summary.
   initial begin
      bit gp [12] = '{0, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0};

      rst       = 1'b1;
      job_valid = 1'b0;
      job_len   = '0;
      job_data  = '0;
      gnt       = 1'b0;
      @(posedge clk);
      modelEdge();
      #1;
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("rst_bus_data", bus_data, 0);
      checkOutput("rst_job_ready", job_ready, 1);

      // Single three-beat job with the grant held high.
      applyStimulus(0, 1, 2, 'h10, 1);
      repeat (8) applyStimulus(0, 0, 0, 0, 1);

      // Grant stall in the middle of a wrapping burst.
      applyStimulus(0, 1, 3, 'hFE, 0);
      for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 0, gp[i]);

      // Fill the FIFO with no grant; the sixth push must be refused.
      for (int i = 0; i < 6; i++) applyStimulus(0, 1, i, 'h40 + 16 * i, 0);
      repeat (60) applyStimulus(0, 0, 0, 0, 1);

      // Reset during beat 1 of a four-beat burst with another job queued.
      applyStimulus(0, 1, 3, 'h80, 1);
      applyStimulus(0, 1, 0, 'h90, 1);
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(1, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("post_rst_busy", busy, 0);
      repeat (4) applyStimulus(0, 0, 0, 0, 1);

      // Long grant drought with two jobs queued, then grants return.
      applyStimulus(0, 1, 1, 'hA0, 0);
      applyStimulus(0, 1, 2, 'hB0, 0);
      repeat (22) applyStimulus(0, 0, 0, 0, 0);
      repeat (14) applyStimulus(0, 0, 0, 0, 1);

      // Randomized soak with occasional resets.
      for (int i = 0; i < 800; i++) begin
         applyStimulus($urandom_range(0, 149) == 0,
                       $urandom_range(0, 2) != 0,
                       int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 255)),
                       $urandom_range(0, 3) != 0);
      end

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
